// File: rtl/fp_clamp_seq.sv
// Sequential single-precision clamp driving a shared external fp comparator.
// Optional saturating clip counter enabled by FP_CLAMP_COUNT_EN.
module fp_clamp_seq
`ifdef FP_CLAMP_COUNT_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic [31:0] lim_lo,
    input  logic [31:0] lim_hi,
    output logic [31:0] cmp_dataa,
    output logic [31:0] cmp_datab,
    input  logic        cmp_leq,
    input  logic        cmp_geq,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
`ifdef FP_CLAMP_COUNT_EN
    ,
    output logic [CNT_W-1:0] clip_count
`endif
);

    localparam int W = 32;

    typedef enum logic [1:0] {
        IDLE,
        CMP_HI,
        CMP_LO,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cmp_a_q, cmp_a_d;
    logic [W-1:0]   cmp_b_q, cmp_b_d;
    logic [W-1:0]   lo_q, lo_d;
    logic [W-1:0]   out_q, out_d;

    // cmp_a holds the sample for the whole transaction; cmp_b walks hi then lo
    always_comb begin
        state_d = state_q;
        cmp_a_d = cmp_a_q;
        cmp_b_d = cmp_b_q;
        lo_d    = lo_q;
        out_d   = out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cmp_a_d = in_data;
                    cmp_b_d = lim_hi;
                    lo_d    = lim_lo;
                    state_d = CMP_HI;
                end
            end
            CMP_HI: begin
                if (cmp_geq && !cmp_leq) begin
                    out_d   = cmp_b_q;
                    state_d = DONE;
                end else begin
                    cmp_b_d = lo_q;
                    state_d = CMP_LO;
                end
            end
            CMP_LO: begin
                if (cmp_leq && !cmp_geq) begin
                    out_d = cmp_b_q;
                end else begin
                    out_d = cmp_a_q;
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cmp_a_q <= '0;
            cmp_b_q <= '0;
            lo_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cmp_a_q <= cmp_a_d;
            cmp_b_q <= cmp_b_d;
            lo_q    <= lo_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_data  = out_q;
    assign cmp_dataa = cmp_a_q;
    assign cmp_datab = cmp_b_q;

`ifdef FP_CLAMP_COUNT_EN
    logic             clip;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign clip = ((state_q == CMP_HI) && cmp_geq && !cmp_leq) ||
                  ((state_q == CMP_LO) && cmp_leq && !cmp_geq);

    always_comb begin
        cnt_d = cnt_q;
        if (clip && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clip_count = cnt_q;
`endif

endmodule
